// File: rtl/wb_stage_pkg.sv
// ISA constants and decode result type shared by the writeback stage.
// The opcode, aluop, special-register and overflow-code values live here.
package wb_stage_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [4:0] RSTATUS = 5'd30;
    localparam logic [4:0] RA      = 5'd31;

    // Zero means "no overflow rewrite"; the others are the value written to rstatus.
    localparam logic [2:0] OVF_NONE = 3'd0;
    localparam logic [2:0] OVF_ADD  = 3'd1;
    localparam logic [2:0] OVF_ADDI = 3'd2;
    localparam logic [2:0] OVF_SUB  = 3'd3;
    localparam logic [2:0] OVF_MUL  = 3'd4;
    localparam logic [2:0] OVF_DIV  = 3'd5;

    typedef struct packed {
        logic       we;
        logic [4:0] waddr;
        logic       selD;
        logic       selT;
        logic [2:0] ovfCode;
    } wb_dec_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational writeback decode: instruction + overflow flag -> write control.
// Non-writers still drive waddr=rd; the enable is what the regfile honours.
module wb_decode
    import wb_stage_pkg::*;
(
    input  logic [31:0] ins,
    input  logic        ovf,
    output wb_dec_t     dec
);

    logic [4:0] op;
    logic [4:0] rd;
    logic [4:0] aluop;
    logic       isNop;
    logic [2:0] ovfCand;
    logic       unusedIns;

    assign op        = ins[31:27];
    assign rd        = ins[26:22];
    assign aluop     = ins[6:2];
    assign isNop     = (ins == 32'd0);
    assign unusedIns = ^{ins[21:7], ins[1:0]};

    always_comb begin
        dec         = '0;
        dec.waddr   = rd;
        ovfCand     = OVF_NONE;
        unique case (op)
            OP_RTYPE: begin
                dec.we = !isNop;
                unique case (aluop)
                    ALU_ADD: ovfCand = OVF_ADD;
                    ALU_SUB: ovfCand = OVF_SUB;
                    ALU_MUL: ovfCand = OVF_MUL;
                    ALU_DIV: ovfCand = OVF_DIV;
                    default: ovfCand = OVF_NONE;
                endcase
            end
            OP_ADDI: begin
                dec.we  = 1'b1;
                ovfCand = OVF_ADDI;
            end
            OP_LW: begin
                dec.we   = 1'b1;
                dec.selD = 1'b1;
            end
            OP_JAL: begin
                dec.we    = 1'b1;
                dec.waddr = RA;
            end
            OP_SETX: begin
                dec.we    = 1'b1;
                dec.waddr = RSTATUS;
                dec.selT  = 1'b1;
            end
            default: dec.we = 1'b0;
        endcase
        // An overflowing arithmetic op is redirected into rstatus with its code as data.
        if (ovf && !isNop && ovfCand != OVF_NONE) begin
            dec.we      = 1'b1;
            dec.waddr   = RSTATUS;
            dec.ovfCode = ovfCand;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits the regfile write, keeps a one-cycle bypass copy,
// and (with WB_PERF_EN defined) counts retired instructions and overflow rewrites.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mw_valid,
    input  logic [31:0]       mw_ins,
    input  logic [DATA_W-1:0] mw_o,
    input  logic [DATA_W-1:0] mw_d,
    input  logic [31:0]       mw_ovf,
    output logic              ctrl_writeEnable,
    output logic [REG_AW-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              byp_valid,
    output logic [REG_AW-1:0] byp_reg,
    output logic [DATA_W-1:0] byp_data,
    output logic [CNT_W-1:0]  retired_count,
    output logic [CNT_W-1:0]  ovf_count
);

    wb_dec_t dec;
    logic    unusedOvf;

    assign unusedOvf = ^mw_ovf[31:1];

    wb_decode uDecode (
        .ins (mw_ins),
        .ovf (mw_ovf[0]),
        .dec (dec)
    );

    assign ctrl_writeReg    = REG_AW'(dec.waddr);
    assign ctrl_writeEnable = mw_valid && !reset && dec.we && (dec.waddr != 5'd0);

    always_comb begin
        if (dec.ovfCode != OVF_NONE) begin
            data_writeReg = DATA_W'(dec.ovfCode);
        end else if (dec.selT) begin
            data_writeReg = DATA_W'(mw_ins[26:0]);
        end else if (dec.selD) begin
            data_writeReg = mw_d;
        end else begin
            data_writeReg = mw_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_valid <= 1'b0;
            byp_reg   <= '0;
            byp_data  <= '0;
        end else begin
            byp_valid <= ctrl_writeEnable;
            byp_reg   <= ctrl_writeReg;
            byp_data  <= data_writeReg;
        end
    end

`ifdef WB_PERF_EN
    logic [CNT_W-1:0] retiredCountReg;
    logic [CNT_W-1:0] ovfCountReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            retiredCountReg <= '0;
            ovfCountReg     <= '0;
        end else if (mw_valid) begin
            retiredCountReg <= retiredCountReg + 1'b1;
            if (dec.ovfCode != OVF_NONE) begin
                ovfCountReg <= ovfCountReg + 1'b1;
            end
        end
    end

    assign retired_count = retiredCountReg;
    assign ovf_count     = ovfCountReg;
`else
    assign retired_count = '0;
    assign ovf_count     = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Table-driven bench for wb_stage with a bypass scoreboard and counter model.
// Counter expectations follow whether WB_PERF_EN is defined for the build.
module tb_wb_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mw_valid;
    logic [31:0] mw_ins;
    logic [31:0] mw_o;
    logic [31:0] mw_d;
    logic [31:0] mw_ovf;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        byp_valid;
    logic [4:0]  byp_reg;
    logic [31:0] byp_data;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] ovf_count;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .mw_valid         (mw_valid),
        .mw_ins           (mw_ins),
        .mw_o             (mw_o),
        .mw_d             (mw_d),
        .mw_ovf           (mw_ovf),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .byp_valid        (byp_valid),
        .byp_reg          (byp_reg),
        .byp_data         (byp_data),
        .retired_count    (retired_count),
        .ovf_count        (ovf_count)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] o;
        logic [31:0] d;
        logic [31:0] ovf;
        logic        expWe;
        logic        chkAddr;
        logic [4:0]  expReg;
        logic [31:0] expData;
        logic        expOvfInc;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [4:0]  regAddr;
        logic [31:0] data;
    } byp_t;

    vec_t vecs[$];
    byp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   expRet = 0;
    int   expOvf = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] aluop);
        return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [16:0] imm);
        return {op, rd, 5'd1, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int cntExp(input int n);
`ifdef WB_PERF_EN
        return n % (1 << CNT_W);
`else
        return 0 * n;
`endif
    endfunction

    task automatic checkCounters(input string tag);
        chk({tag, ".retired"}, 32'(retired_count), 32'(cntExp(expRet)));
        chk({tag, ".ovfcnt"}, 32'(ovf_count), 32'(cntExp(expOvf)));
    endtask

    task automatic addVec(input string name, input logic valid, input logic [31:0] ins,
                          input logic [31:0] o, input logic [31:0] d, input logic [31:0] ovf,
                          input logic we, input logic chkAddr, input logic [4:0] r,
                          input logic [31:0] data, input logic ovfInc);
        vec_t v;
        v.name = name; v.valid = valid; v.ins = ins; v.o = o; v.d = d; v.ovf = ovf;
        v.expWe = we; v.chkAddr = chkAddr; v.expReg = r; v.expData = data;
        v.expOvfInc = ovfInc;
        vecs.push_back(v);
    endtask

    // Drive one instruction, check the combinational write, then the bypass after the edge.
    task automatic applyVec(input vec_t v);
        byp_t e;
        byp_t got;
        @(negedge clk);
        mw_valid = v.valid; mw_ins = v.ins; mw_o = v.o; mw_d = v.d; mw_ovf = v.ovf;
        #1;
        chk({v.name, ".we"}, 32'(ctrl_writeEnable), 32'(v.expWe));
        if (v.chkAddr) begin
            chk({v.name, ".reg"}, 32'(ctrl_writeReg), 32'(v.expReg));
            chk({v.name, ".data"}, data_writeReg, v.expData);
        end
        e.valid = v.expWe; e.regAddr = v.expReg; e.data = v.expData;
        sb.push_back(e);
        if (v.valid) expRet++;
        if (v.valid && v.expOvfInc) expOvf++;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({v.name, ".byp_valid"}, 32'(byp_valid), 32'(got.valid));
        if (got.valid) begin
            chk({v.name, ".byp_reg"}, 32'(byp_reg), 32'(got.regAddr));
            chk({v.name, ".byp_data"}, byp_data, got.data);
        end
        $display("txn %-10s ins=%08h we=%0b reg=%0d data=%08h byp=%0b/%0d/%08h ret=%0d ovf=%0d",
                 v.name, v.ins, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
                 byp_valid, byp_reg, byp_data, retired_count, ovf_count);
        checkCounters(v.name);
    endtask

    initial begin
        reset = 1'b1; mw_valid = 1'b0; mw_ins = '0; mw_o = '0; mw_d = '0; mw_ovf = '0;

        addVec("add3",   1, rtype(5'd3, 5'b00000), 32'd7, 32'd0, 32'd0, 1, 1, 5'd3, 32'd7, 0);
        addVec("lw5",    1, itype(5'b01000, 5'd5, 17'd0), 32'h10, 32'hDEADBEEF, 32'd0,
               1, 1, 5'd5, 32'hDEADBEEF, 0);
        addVec("addiOvf",1, itype(5'b00101, 5'd4, 17'd9), 32'd123, 32'd0, 32'd1,
               1, 1, 5'd30, 32'd2, 1);
        addVec("subOvf", 1, rtype(5'd6, 5'b00001), 32'd55, 32'd0, 32'd1, 1, 1, 5'd30, 32'd3, 1);
        addVec("swOvf",  1, itype(5'b00111, 5'd7, 17'd4), 32'h44, 32'd0, 32'd1, 0, 0, 5'd0, 32'd0, 0);
        addVec("add0",   1, rtype(5'd0, 5'b00000), 32'd9, 32'd0, 32'd0, 0, 1, 5'd0, 32'd9, 0);
        addVec("jal",    1, {5'b00011, 27'd100}, 32'h21, 32'd0, 32'd0, 1, 1, 5'd31, 32'h21, 0);
        addVec("setx5",  1, {5'b10101, 27'd5}, 32'hFF, 32'd0, 32'd0, 1, 1, 5'd30, 32'd5, 0);
        addVec("mulOvf", 1, rtype(5'd8, 5'b00110), 32'd1, 32'd0, 32'd1, 1, 1, 5'd30, 32'd4, 1);
        addVec("divOvf", 1, rtype(5'd8, 5'b00111), 32'd1, 32'd0, 32'd1, 1, 1, 5'd30, 32'd5, 1);
        addVec("addOvf", 1, rtype(5'd2, 5'b00000), 32'd1, 32'd0, 32'd1, 1, 1, 5'd30, 32'd1, 1);
        addVec("andOvf", 1, rtype(5'd9, 5'b00010), 32'hAA, 32'd0, 32'd1, 1, 1, 5'd9, 32'hAA, 0);
        addVec("bneOvf", 1, itype(5'b00010, 5'd3, 17'd2), 32'd5, 32'd0, 32'd1, 0, 0, 5'd0, 32'd0, 0);
        addVec("nop",    1, 32'd0, 32'd0, 32'd0, 32'd1, 0, 0, 5'd0, 32'd0, 0);
        addVec("bubble", 0, rtype(5'd3, 5'b00000), 32'd7, 32'd0, 32'd1, 0, 0, 5'd0, 32'd0, 0);
        addVec("j",      1, {5'b00001, 27'd40}, 32'd1, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        addVec("jr",     1, itype(5'b00100, 5'd31, 17'd0), 32'd1, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        addVec("bex",    1, {5'b10110, 27'd12}, 32'd1, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        addVec("setxMax",1, {5'b10101, 27'h7FFFFFF}, 32'd0, 32'd0, 32'd0,
               1, 1, 5'd30, 32'h07FFFFFF, 0);
        addVec("ovfBit1",1, rtype(5'd10, 5'b00000), 32'h55, 32'd0, 32'd2, 1, 1, 5'd10, 32'h55, 0);
        addVec("sll11",  1, rtype(5'd11, 5'b00100), 32'h80, 32'd0, 32'd0, 1, 1, 5'd11, 32'h80, 0);
        addVec("lwO",    1, itype(5'b01000, 5'd12, 17'd3), 32'h1234, 32'h0BAD, 32'd1,
               1, 1, 5'd12, 32'h0BAD, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst.byp_valid", 32'(byp_valid), 32'd0);
        chk("rst.byp_reg", 32'(byp_reg), 32'd0);
        chk("rst.byp_data", byp_data, 32'd0);
        checkCounters("rst");
        @(negedge clk);
        #1;
        chk("rst.we", 32'(ctrl_writeEnable), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) applyVec(vecs[i]);

        // Reset asserted together with a valid writer: reset wins.
        @(negedge clk);
        reset = 1'b1; mw_valid = 1'b1; mw_ins = rtype(5'd3, 5'b00000); mw_o = 32'd7; mw_ovf = 32'd1;
        #1;
        chk("rstValid.we", 32'(ctrl_writeEnable), 32'd0);
        @(posedge clk);
        #1;
        expRet = 0; expOvf = 0;
        chk("rstValid.byp_valid", 32'(byp_valid), 32'd0);
        chk("rstValid.byp_reg", 32'(byp_reg), 32'd0);
        chk("rstValid.byp_data", byp_data, 32'd0);
        checkCounters("rstValid");
        $display("txn rstValid   byp=%0b/%0d/%08h ret=%0d ovf=%0d",
                 byp_valid, byp_reg, byp_data, retired_count, ovf_count);
        @(negedge clk);
        reset = 1'b0;

        // Run one full counter period: count reaches all-ones then wraps to 0.
        for (int n = 1; n <= (1 << CNT_W); n++) begin
            vec_t w;
            w.name = $sformatf("wrap%0d", n); w.valid = 1'b1;
            w.ins = rtype(5'd1, 5'b00000); w.o = 32'(n); w.d = 32'd0; w.ovf = 32'd1;
            w.expWe = 1'b1; w.chkAddr = 1'b1; w.expReg = 5'd30; w.expData = 32'd1;
            w.expOvfInc = 1'b1;
            applyVec(w);
        end
        chk("wrap.retired_final", 32'(retired_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
